// File: rtl/ndp_load_sequencer.sv
// Load/drain sequencer: streams words into activation then weight BRAMs per layer,
// then replays the buffered layers into the NDP unit and waits for its result.
module ndp_load_sequencer #(
    parameter int DATA_W      = 32,
    parameter int SYS_HEIGHT  = 1,
    parameter int SYS_WIDTH   = 64,
    parameter int ACT_WORDS   = 2,
    parameter int WGT_WORDS   = 2,
    parameter int BUFFER_SIZE = 5,
    localparam int AN_W = (SYS_HEIGHT  > 1) ? $clog2(SYS_HEIGHT)      : 1,
    localparam int AA_W = (ACT_WORDS   > 1) ? $clog2(ACT_WORDS)       : 1,
    localparam int WN_W = (SYS_WIDTH   > 1) ? $clog2(SYS_WIDTH)       : 1,
    localparam int WA_W = (WGT_WORDS   > 1) ? $clog2(WGT_WORDS)       : 1,
    localparam int LW   = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE)     : 1,
    localparam int CW   = $clog2(BUFFER_SIZE + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              data_in_flag,
    input  logic [DATA_W-1:0] data_in,
    input  logic              calc_done_flag,
    output logic [2:0]        step,
    output logic [DATA_W-1:0] data_received,
    output logic [AN_W-1:0]   act_bram_num,
    output logic [AA_W-1:0]   act_bram_addr,
    output logic              act_wr_en,
    output logic [WN_W-1:0]   weight_bram_num,
    output logic [WA_W-1:0]   weight_bram_addr,
    output logic              weight_wr_en,
    output logic [LW-1:0]     bram_layer,
    output logic [LW-1:0]     data_address_into_ndp_unit,
    output logic              ndp_unit_reset,
    output logic              ndp_unit_in_done_flag,
    output logic [CW-1:0]     layers_loaded,
    output logic              trunc_err,
    output logic              overflow_err
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD_ACT = 3'd1,
        S_LOAD_WGT = 3'd2,
        S_DRAIN    = 3'd3,
        S_DONE     = 3'd4,
        S_ERROR    = 3'd5
    } state_t;

    state_t state, state_next;
    logic   flag_q;
    logic   act_last, wgt_last, act_boundary, buffer_full, drain_last;

    assign step         = state;
    assign act_wr_en    = (state == S_LOAD_ACT) && flag_q;
    assign weight_wr_en = (state == S_LOAD_WGT) && flag_q;

    assign act_last     = (act_bram_num == AN_W'(SYS_HEIGHT - 1)) &&
                          (act_bram_addr == AA_W'(ACT_WORDS - 1));
    assign wgt_last     = (weight_bram_num == WN_W'(SYS_WIDTH - 1)) &&
                          (weight_bram_addr == WA_W'(WGT_WORDS - 1));
    assign act_boundary = (act_bram_num == '0) && (act_bram_addr == '0) &&
                          (layers_loaded != '0);
    assign buffer_full  = (int'(layers_loaded) + 1) == BUFFER_SIZE;
    assign drain_last   = int'(data_address_into_ndp_unit) == (int'(layers_loaded) - 1);

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // NOTE: state_next gets a default before the case so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:     if (data_in_flag) state_next = S_LOAD_ACT;
            S_LOAD_ACT: begin
                if (flag_q) begin
                    if (act_last) state_next = S_LOAD_WGT;
                end else begin
                    state_next = act_boundary ? S_DRAIN : S_ERROR;
                end
            end
            S_LOAD_WGT: begin
                if (flag_q) begin
                    if (wgt_last) state_next = buffer_full ? S_DRAIN : S_LOAD_ACT;
                end else begin
                    state_next = S_ERROR;
                end
            end
            S_DRAIN:    if (drain_last) state_next = S_DONE;
            S_DONE:     if (calc_done_flag) state_next = S_IDLE;
            S_ERROR:    state_next = S_ERROR;
            default:    state_next = S_ERROR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flag_q                     <= 1'b0;
            data_received              <= '0;
            act_bram_num               <= '0;
            act_bram_addr              <= '0;
            weight_bram_num            <= '0;
            weight_bram_addr           <= '0;
            bram_layer                 <= '0;
            data_address_into_ndp_unit <= '0;
            ndp_unit_reset             <= 1'b1;
            ndp_unit_in_done_flag      <= 1'b0;
            layers_loaded              <= '0;
            trunc_err                  <= 1'b0;
            overflow_err               <= 1'b0;
        end else begin
            data_received <= data_in;
            flag_q        <= data_in_flag;

            // Words arriving while the buffer is being replayed have nowhere to go.
            if (flag_q && (state == S_DRAIN || state == S_DONE)) overflow_err <= 1'b1;

            case (state)
                S_IDLE: begin
                    act_bram_num               <= '0;
                    act_bram_addr              <= '0;
                    weight_bram_num            <= '0;
                    weight_bram_addr           <= '0;
                    bram_layer                 <= '0;
                    layers_loaded              <= '0;
                    data_address_into_ndp_unit <= '0;
                end
                S_LOAD_ACT: begin
                    if (flag_q) begin
                        if (act_last) begin
                            act_bram_num     <= '0;
                            act_bram_addr    <= '0;
                            weight_bram_num  <= '0;
                            weight_bram_addr <= '0;
                        end else if (act_bram_addr == AA_W'(ACT_WORDS - 1)) begin
                            act_bram_addr <= '0;
                            act_bram_num  <= act_bram_num + 1'b1;
                        end else begin
                            act_bram_addr <= act_bram_addr + 1'b1;
                        end
                    end else if (act_boundary) begin
                        ndp_unit_reset             <= 1'b0;
                        data_address_into_ndp_unit <= '0;
                    end else begin
                        trunc_err      <= 1'b1;
                        ndp_unit_reset <= 1'b1;
                    end
                end
                S_LOAD_WGT: begin
                    if (flag_q) begin
                        if (wgt_last) begin
                            weight_bram_num  <= '0;
                            weight_bram_addr <= '0;
                            act_bram_num     <= '0;
                            act_bram_addr    <= '0;
                            layers_loaded    <= layers_loaded + 1'b1;
                            bram_layer       <= bram_layer + 1'b1;
                            if (buffer_full) begin
                                ndp_unit_reset             <= 1'b0;
                                data_address_into_ndp_unit <= '0;
                            end
                        end else if (weight_bram_addr == WA_W'(WGT_WORDS - 1)) begin
                            weight_bram_addr <= '0;
                            weight_bram_num  <= weight_bram_num + 1'b1;
                        end else begin
                            weight_bram_addr <= weight_bram_addr + 1'b1;
                        end
                    end else begin
                        trunc_err      <= 1'b1;
                        ndp_unit_reset <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (drain_last) ndp_unit_in_done_flag <= 1'b1;
                    else data_address_into_ndp_unit <= data_address_into_ndp_unit + 1'b1;
                end
                S_DONE: begin
                    if (calc_done_flag) begin
                        ndp_unit_in_done_flag      <= 1'b0;
                        ndp_unit_reset             <= 1'b1;
                        data_address_into_ndp_unit <= '0;
                        bram_layer                 <= '0;
                        layers_loaded              <= '0;
                        act_bram_num               <= '0;
                        act_bram_addr              <= '0;
                        weight_bram_num            <= '0;
                        weight_bram_addr           <= '0;
                    end
                end
                default: ndp_unit_reset <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_ndp_load_sequencer.sv
// Scoreboard bench for ndp_load_sequencer: expected BRAM writes and drain addresses are
// queued as stimulus is driven and popped by a negedge monitor as the DUT produces them.
module tb_ndp_load_sequencer;

    localparam int DATA_W = 32;
    localparam int SH = 2, SW = 4, AW = 2, WW = 2, BS = 3;
    localparam int AN_W = 1, AA_W = 1, WN_W = 2, WA_W = 1, LW = 2, CW = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              data_in_flag = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic              calc_done_flag = 1'b0;
    logic [2:0]        step;
    logic [DATA_W-1:0] data_received;
    logic [AN_W-1:0]   act_bram_num;
    logic [AA_W-1:0]   act_bram_addr;
    logic              act_wr_en;
    logic [WN_W-1:0]   weight_bram_num;
    logic [WA_W-1:0]   weight_bram_addr;
    logic              weight_wr_en;
    logic [LW-1:0]     bram_layer;
    logic [LW-1:0]     data_address_into_ndp_unit;
    logic              ndp_unit_reset;
    logic              ndp_unit_in_done_flag;
    logic [CW-1:0]     layers_loaded;
    logic              trunc_err;
    logic              overflow_err;

    ndp_load_sequencer #(
        .DATA_W(DATA_W), .SYS_HEIGHT(SH), .SYS_WIDTH(SW),
        .ACT_WORDS(AW), .WGT_WORDS(WW), .BUFFER_SIZE(BS)
    ) dut (
        .clk(clk), .reset(reset), .data_in_flag(data_in_flag), .data_in(data_in),
        .calc_done_flag(calc_done_flag), .step(step), .data_received(data_received),
        .act_bram_num(act_bram_num), .act_bram_addr(act_bram_addr), .act_wr_en(act_wr_en),
        .weight_bram_num(weight_bram_num), .weight_bram_addr(weight_bram_addr),
        .weight_wr_en(weight_wr_en), .bram_layer(bram_layer),
        .data_address_into_ndp_unit(data_address_into_ndp_unit),
        .ndp_unit_reset(ndp_unit_reset), .ndp_unit_in_done_flag(ndp_unit_in_done_flag),
        .layers_loaded(layers_loaded), .trunc_err(trunc_err), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;   // 0 activation, 1 weight
        int num;
        int addr;
        int layer;
        int data;
    } wr_t;

    wr_t wr_q[$];
    int  drain_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    // Queue the first `count` writes of one layer whose first word carries `base`.
    function automatic void push_layer(int layer, int base, int count);
        int k = 0;
        for (int n = 0; n < SH; n++)
            for (int a = 0; a < AW; a++) begin
                if (k < count) wr_q.push_back('{0, n, a, layer, base + k});
                k++;
            end
        for (int n = 0; n < SW; n++)
            for (int a = 0; a < WW; a++) begin
                if (k < count) wr_q.push_back('{1, n, a, layer, base + k});
                k++;
            end
    endfunction

    always @(negedge clk) begin
        if (act_wr_en === 1'b1 || weight_wr_en === 1'b1) begin
            wr_t e;
            wr_t g;
            n_checks++;
            if (act_wr_en === 1'b1 && weight_wr_en === 1'b1) begin
                n_fail++;
                $display("FAIL wr_en_both: act_wr_en=1 weight_wr_en=1, required one at a time");
            end else if (wr_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: act=%0b wgt=%0b data=%0d, required no write",
                         act_wr_en, weight_wr_en, data_received);
            end else begin
                e = wr_q.pop_front();
                if (act_wr_en === 1'b1)
                    g = '{0, int'(act_bram_num), int'(act_bram_addr), int'(bram_layer), int'(data_received)};
                else
                    g = '{1, int'(weight_bram_num), int'(weight_bram_addr), int'(bram_layer), int'(data_received)};
                if (g.kind != e.kind || g.num != e.num || g.addr != e.addr ||
                    g.layer != e.layer || g.data != e.data) begin
                    n_fail++;
                    $display("FAIL write: got kind=%0d num=%0d addr=%0d layer=%0d data=%0d, required kind=%0d num=%0d addr=%0d layer=%0d data=%0d",
                             g.kind, g.num, g.addr, g.layer, g.data, e.kind, e.num, e.addr, e.layer, e.data);
                end
            end
        end
        if (step === 3'd3) begin
            int ea;
            n_checks++;
            if (drain_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_drain: addr=%0d, required no drain cycle",
                         data_address_into_ndp_unit);
            end else begin
                ea = drain_q.pop_front();
                if (int'(data_address_into_ndp_unit) != ea || ndp_unit_reset !== 1'b0) begin
                    n_fail++;
                    $display("FAIL drain: addr=%0d ndp_unit_reset=%0b, required addr=%0d ndp_unit_reset=0",
                             data_address_into_ndp_unit, ndp_unit_reset, ea);
                end
            end
        end
    end

    task automatic apply_reset();
        reset = 1'b1;
        data_in_flag = 1'b0;
        calc_done_flag = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        wr_q.delete();
        drain_q.delete();
    endtask

    task automatic stream(int n, int base);
        for (int i = 0; i < n; i++) begin
            data_in_flag = 1'b1;
            data_in = DATA_W'(base + i);
            @(posedge clk);
            #1;
        end
        data_in_flag = 1'b0;
        data_in = '0;
    endtask

    task automatic wait_done(string name, int exp_lat);
        int n = 0;
        bit seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n++;
            if (step === 3'd4) begin
                seen = 1;
                break;
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s_done_timeout: step=%0d after %0d cycles, required 4", name, step, n);
        end else if (n != exp_lat) begin
            n_fail++;
            $display("FAIL %s_done_latency: %0d cycles, required %0d", name, n, exp_lat);
        end
        n_checks++;
        if (ndp_unit_in_done_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_in_done: %0b, required 1", name, ndp_unit_in_done_flag);
        end
    endtask

    task automatic check_drained(string name);
        n_checks++;
        if (wr_q.size() != 0 || drain_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_pending: writes=%0d drains=%0d left, required 0 0",
                     name, wr_q.size(), drain_q.size());
        end
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        n_checks++;
        if (step !== 3'd0 || ndp_unit_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: step=%0d ndp_unit_reset=%0b, required 0 1", step, ndp_unit_reset);
        end
        n_checks++;
        if ({data_received, act_bram_num, act_bram_addr, act_wr_en, weight_bram_num,
             weight_bram_addr, weight_wr_en, bram_layer, data_address_into_ndp_unit,
             ndp_unit_in_done_flag, layers_loaded, trunc_err, overflow_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: data=%0h layers=%0d in_done=%0b trunc=%0b ovf=%0b, required all 0",
                     data_received, layers_loaded, ndp_unit_in_done_flag, trunc_err, overflow_err);
        end
    endtask

    task automatic test_single_layer();
        push_layer(0, 1, 12);
        drain_q.push_back(0);
        stream(12, 1);
        wait_done("single", 4);
        n_checks++;
        if (layers_loaded !== 2'd1 || overflow_err !== 1'b0 || trunc_err !== 1'b0) begin
            n_fail++;
            $display("FAIL single_status: layers=%0d ovf=%0b trunc=%0b, required 1 0 0",
                     layers_loaded, overflow_err, trunc_err);
        end
        check_drained("single");
    endtask

    task automatic test_restart();
        calc_done_flag = 1'b1;
        @(posedge clk);
        #1 calc_done_flag = 1'b0;
        @(negedge clk);
        n_checks++;
        if (step !== 3'd0 || ndp_unit_in_done_flag !== 1'b0 || ndp_unit_reset !== 1'b1 ||
            layers_loaded !== '0 || bram_layer !== '0) begin
            n_fail++;
            $display("FAIL restart_idle: step=%0d in_done=%0b ndp_reset=%0b layers=%0d layer=%0d, required 0 0 1 0 0",
                     step, ndp_unit_in_done_flag, ndp_unit_reset, layers_loaded, bram_layer);
        end
        push_layer(0, 100, 12);
        drain_q.push_back(0);
        stream(12, 100);
        wait_done("restart", 4);
        n_checks++;
        if (layers_loaded !== 2'd1) begin
            n_fail++;
            $display("FAIL restart_layers: %0d, required 1", layers_loaded);
        end
        check_drained("restart");
    endtask

    task automatic test_buffer_full();
        apply_reset();
        for (int l = 0; l < BS; l++) begin
            push_layer(l, 1 + 12 * l, 12);
            drain_q.push_back(l);
        end
        stream(38, 1);
        wait_done("full", 3);
        n_checks++;
        if (layers_loaded !== 2'd3 || overflow_err !== 1'b1 || trunc_err !== 1'b0) begin
            n_fail++;
            $display("FAIL full_status: layers=%0d ovf=%0b trunc=%0b, required 3 1 0",
                     layers_loaded, overflow_err, trunc_err);
        end
        check_drained("full");
    endtask

    task automatic test_truncation();
        apply_reset();
        push_layer(0, 1, 7);
        stream(7, 1);
        repeat (2) @(posedge clk);
        #1;
        stream(4, 50);
        @(negedge clk);
        n_checks++;
        if (step !== 3'd5 || trunc_err !== 1'b1 || ndp_unit_reset !== 1'b1 || overflow_err !== 1'b0) begin
            n_fail++;
            $display("FAIL trunc_state: step=%0d trunc=%0b ndp_reset=%0b ovf=%0b, required 5 1 1 0",
                     step, trunc_err, ndp_unit_reset, overflow_err);
        end
        check_drained("trunc");
    endtask

    task automatic test_reset_mid_load();
        apply_reset();
        push_layer(0, 1, 8);
        stream(8, 1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (step !== 3'd0 || ndp_unit_reset !== 1'b1 || trunc_err !== 1'b0 ||
            weight_bram_num !== '0 || act_bram_num !== '0 || layers_loaded !== '0) begin
            n_fail++;
            $display("FAIL midreset_state: step=%0d ndp_reset=%0b trunc=%0b wnum=%0d anum=%0d layers=%0d, required 0 1 0 0 0 0",
                     step, ndp_unit_reset, trunc_err, weight_bram_num, act_bram_num, layers_loaded);
        end
        check_drained("midreset_partial");
        push_layer(0, 200, 12);
        drain_q.push_back(0);
        stream(12, 200);
        wait_done("midreset", 4);
        n_checks++;
        if (layers_loaded !== 2'd1 || overflow_err !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_status: layers=%0d ovf=%0b, required 1 0", layers_loaded, overflow_err);
        end
        check_drained("midreset");
    endtask

    initial begin
        test_reset();
        test_single_layer();
        test_restart();
        test_buffer_full();
        test_truncation();
        test_reset_mid_load();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
